redmule_axi_mem_responder: RTL and testbench



---
 rtl/redmule_axi_mem_rsp_pkg.sv | 72 +++++++
 rtl/redmule_axi_mem_rsp_array.sv | 53 +++++
 rtl/redmule_axi_mem_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_redmule_axi_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_axi_mem_rsp_pkg.sv
// Package for the RedMulE AXI memory responder.
// Holds the write/read FSM state enums, the AXI response and burst encodings,
// and the default AXI request/response channel structs (4-bit ID,
// 32-bit address, 32-bit data) used as the responder's port types.
package redmule_axi_mem_rsp_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_default_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_default_rsp_t;

endpackage

// File: rtl/redmule_axi_mem_rsp_array.sv
// Single-port, byte-enabled word array with a registered read and a
// write-priority arbiter.
// Ports:
//   clk_i, rst_ni        : clock, synchronous active-low reset (read register only)
//   wr_en/wr_idx/wr_data/wr_strb : write request, byte lanes selected by wr_strb
//   rd_en/rd_idx/rd_clr  : read fetch request; rd_clr loads zero instead of memory
//   rd_gnt               : fetch granted this cycle (no write competing for the port)
//   rd_data              : registered read data, changes only on a granted fetch
module redmule_axi_mem_rsp_array #(
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned N_WORDS = 4096,
    localparam int unsigned IDX_W   = $clog2(N_WORDS),
    localparam int unsigned STRB_W  = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic              rd_clr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [N_WORDS];
    logic [DATA_W-1:0] rd_data_r;

    // A write always owns the port; a competing fetch must retry next cycle.
    assign rd_gnt  = rd_en & ~wr_en;
    assign rd_data = rd_data_r;

    // Byte-lane write into the array; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (wr_en && wr_strb[b]) begin
                mem_r[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // Registered read port, held between granted fetches so R payload stays stable.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_gnt) begin
            rd_data_r <= rd_clr ? {DATA_W{1'b0}} : mem_r[rd_idx];
        end
    end

endmodule

// File: rtl/redmule_axi_mem_responder.sv
// AXI4 subordinate memory model answering a RedMulE tile manager port.
// Serves one write burst and one read burst concurrently; reads return after
// RD_LATENCY idle cycles, every write burst gets a B response.
// Optional build macro: REDMULE_AXI_MEM_RSP_ERR_EN -- out-of-range beats get
// SLVERR (writes discarded, reads return zero). Without it addresses alias
// modulo the array size and every response is OKAY.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   axi_req_i     : AW/W/AR channels plus b_ready and r_ready
//   axi_rsp_o     : aw/w/ar readys, B and R channels (all driven from flops)
//   busy_o        : high while either FSM is out of IDLE
module redmule_axi_mem_responder
    import redmule_axi_mem_rsp_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       ID_W       = 4,
    parameter int unsigned       N_WORDS    = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0,
    parameter int unsigned       RD_LATENCY = 2,
    parameter type               req_t      = axi_default_req_t,
    parameter type               rsp_t      = axi_default_rsp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  req_t axi_req_i,
    output rsp_t axi_rsp_o,
    output logic busy_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(N_WORDS);

    // Word index relative to BASE_ADDR, truncated so that addresses alias.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> OFF_W);
    endfunction

    w_state_e          w_state_r;
    logic              aw_ready_r, w_ready_r, b_valid_r, w_err_r, w_busy_r;
    logic [ID_W-1:0]   b_id_r;
    logic [1:0]        b_resp_r, w_burst_r;
    logic [ADDR_W-1:0] w_addr_r;

    r_state_e          r_state_r;
    logic              ar_ready_r, r_valid_r, r_last_r, r_busy_r;
    logic [ID_W-1:0]   r_id_r;
    logic [1:0]        r_resp_r, r_burst_r;
    logic [ADDR_W-1:0] r_addr_r;
    logic [7:0]        r_len_r, r_beat_r;
    logic [3:0]        r_cnt_r;

    logic              aw_hs_s, w_hs_s, b_hs_s, ar_hs_s;
    logic              w_oor_s, r_oor_s, wr_en_s, rd_req_s, rd_gnt_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              unused_s;

`ifdef REDMULE_AXI_MEM_RSP_ERR_EN
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(N_WORDS * STRB_W);

    // Compare in ADDR_W+1 bits so BASE_ADDR + SPAN cannot wrap.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] base_ext;
        base_ext = {1'b0, BASE_ADDR};
        return ({1'b0, addr} >= base_ext) && ({1'b0, addr} < base_ext + SPAN);
    endfunction

    assign w_oor_s = ~in_range(w_addr_r);
    assign r_oor_s = ~in_range(r_addr_r);
`else
    assign w_oor_s = 1'b0;
    assign r_oor_s = 1'b0;
`endif

    assign aw_hs_s = axi_req_i.aw_valid & aw_ready_r;
    assign w_hs_s  = axi_req_i.w_valid  & w_ready_r;
    assign b_hs_s  = axi_req_i.b_ready  & b_valid_r;
    assign ar_hs_s = axi_req_i.ar_valid & ar_ready_r;

    // Gated by rst_ni so nothing commits in a cycle where reset is sampled.
    assign wr_en_s  = rst_ni & w_hs_s & ~w_oor_s;
    // Fetch slots: last R_WAIT cycle, and R_DATA while no beat is presented.
    assign rd_req_s = rst_ni & (((r_state_r == R_WAIT) && (r_cnt_r == 4'd0)) ||
                                ((r_state_r == R_DATA) && !r_valid_r));

    assign unused_s = ^{axi_req_i.aw.len, axi_req_i.aw.size, axi_req_i.ar.size};

    redmule_axi_mem_rsp_array #(
        .DATA_W  (DATA_W),
        .N_WORDS (N_WORDS)
    ) i_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_en   (wr_en_s),
        .wr_idx  (word_idx(w_addr_r)),
        .wr_data (axi_req_i.w.data),
        .wr_strb (axi_req_i.w.strb),
        .rd_en   (rd_req_s),
        .rd_idx  (word_idx(r_addr_r)),
        .rd_clr  (r_oor_s),
        .rd_gnt  (rd_gnt_s),
        .rd_data (rd_data_s)
    );

    // Write FSM: accept AW, absorb W beats until w_last, then hold B until b_ready.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_state_r  <= W_IDLE;
            aw_ready_r <= 1'b0;
            w_ready_r  <= 1'b0;
            b_valid_r  <= 1'b0;
            b_id_r     <= {ID_W{1'b0}};
            b_resp_r   <= RESP_OKAY;
            w_addr_r   <= {ADDR_W{1'b0}};
            w_burst_r  <= BURST_INCR;
            w_err_r    <= 1'b0;
            w_busy_r   <= 1'b0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    aw_ready_r <= 1'b1;
                    if (aw_hs_s) begin
                        b_id_r     <= axi_req_i.aw.id;
                        w_addr_r   <= axi_req_i.aw.addr;
                        w_burst_r  <= axi_req_i.aw.burst;
                        w_err_r    <= 1'b0;
                        aw_ready_r <= 1'b0;
                        w_ready_r  <= 1'b1;
                        w_busy_r   <= 1'b1;
                        w_state_r  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        if (w_oor_s) begin
                            w_err_r <= 1'b1;
                        end
                        // WRAP is handled as INCR; only FIXED holds the address.
                        if (w_burst_r != BURST_FIXED) begin
                            w_addr_r <= w_addr_r + ADDR_W'(STRB_W);
                        end
                        if (axi_req_i.w.last) begin
                            w_ready_r <= 1'b0;
                            b_valid_r <= 1'b1;
                            b_resp_r  <= (w_err_r | w_oor_s) ? RESP_SLVERR : RESP_OKAY;
                            w_state_r <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs_s) begin
                        b_valid_r  <= 1'b0;
                        aw_ready_r <= 1'b1;
                        w_busy_r   <= 1'b0;
                        w_state_r  <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r  <= W_IDLE;
                    aw_ready_r <= 1'b0;
                    w_ready_r  <= 1'b0;
                    b_valid_r  <= 1'b0;
                    w_busy_r   <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: accept AR, wait RD_LATENCY, then fetch/present each beat in turn.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state_r  <= R_IDLE;
            ar_ready_r <= 1'b0;
            r_valid_r  <= 1'b0;
            r_last_r   <= 1'b0;
            r_id_r     <= {ID_W{1'b0}};
            r_resp_r   <= RESP_OKAY;
            r_addr_r   <= {ADDR_W{1'b0}};
            r_burst_r  <= BURST_INCR;
            r_len_r    <= 8'd0;
            r_beat_r   <= 8'd0;
            r_cnt_r    <= 4'd0;
            r_busy_r   <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    ar_ready_r <= 1'b1;
                    if (ar_hs_s) begin
                        r_id_r     <= axi_req_i.ar.id;
                        r_addr_r   <= axi_req_i.ar.addr;
                        r_len_r    <= axi_req_i.ar.len;
                        r_burst_r  <= axi_req_i.ar.burst;
                        r_beat_r   <= 8'd0;
                        r_cnt_r    <= 4'(RD_LATENCY);
                        ar_ready_r <= 1'b0;
                        r_busy_r   <= 1'b1;
                        r_state_r  <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    // The first fetch is issued in the cycle the counter sits at zero.
                    if (r_cnt_r != 4'd0) begin
                        r_cnt_r <= r_cnt_r - 4'd1;
                    end else if (rd_gnt_s) begin
                        r_valid_r <= 1'b1;
                        r_last_r  <= (r_beat_r == r_len_r);
                        r_resp_r  <= r_oor_s ? RESP_SLVERR : RESP_OKAY;
                        r_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_valid_r) begin
                        if (axi_req_i.r_ready) begin
                            r_valid_r <= 1'b0;
                            if (r_last_r) begin
                                r_last_r   <= 1'b0;
                                ar_ready_r <= 1'b1;
                                r_busy_r   <= 1'b0;
                                r_state_r  <= R_IDLE;
                            end else begin
                                r_beat_r <= r_beat_r + 8'd1;
                                if (r_burst_r != BURST_FIXED) begin
                                    r_addr_r <= r_addr_r + ADDR_W'(STRB_W);
                                end
                            end
                        end
                    end else if (rd_gnt_s) begin
                        r_valid_r <= 1'b1;
                        r_last_r  <= (r_beat_r == r_len_r);
                        r_resp_r  <= r_oor_s ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                default: begin
                    r_state_r  <= R_IDLE;
                    ar_ready_r <= 1'b0;
                    r_valid_r  <= 1'b0;
                    r_last_r   <= 1'b0;
                    r_busy_r   <= 1'b0;
                end
            endcase
        end
    end

    // Pack the registered handshake and payload state into the response struct.
    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = aw_ready_r;
        axi_rsp_o.w_ready  = w_ready_r;
        axi_rsp_o.ar_ready = ar_ready_r;
        axi_rsp_o.b_valid  = b_valid_r;
        axi_rsp_o.b.id     = b_id_r;
        axi_rsp_o.b.resp   = b_resp_r;
        axi_rsp_o.r_valid  = r_valid_r;
        axi_rsp_o.r.id     = r_id_r;
        axi_rsp_o.r.data   = rd_data_s;
        axi_rsp_o.r.resp   = r_resp_r;
        axi_rsp_o.r.last   = r_last_r;
    end

    assign busy_o = w_busy_r | r_busy_r;

endmodule

// File: tb/tb_redmule_axi_mem_responder.sv
// Scoreboard bench for redmule_axi_mem_responder: stimulus tasks queue the
// expected B and R responses, a negedge monitor pops and compares them on
// every completed handshake.
module tb_redmule_axi_mem_responder;
    import redmule_axi_mem_rsp_pkg::*;

    localparam int RD_LAT = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_exp_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    logic             clk = 1'b0;
    logic             rst_ni;
    axi_default_req_t req;
    axi_default_rsp_t rsp;
    logic             busy;

    int checks = 0;
    int failures = 0;

    r_exp_t exp_r[$];
    b_exp_t exp_b[$];
    logic [31:0] wdata [8];
    logic [3:0]  wstrb [8];

`ifdef REDMULE_AXI_MEM_RSP_ERR_EN
    localparam logic [1:0]  OOR_RESP  = RESP_SLVERR;
    localparam logic [31:0] OOR_RDATA = 32'h0000_0000;
    localparam logic [31:0] W0_DATA   = 32'h0BAD_F00D;
`else
    localparam logic [1:0]  OOR_RESP  = RESP_OKAY;
    localparam logic [31:0] OOR_RDATA = 32'hCAFE_F00D;
    localparam logic [31:0] W0_DATA   = 32'hCAFE_F00D;
`endif

    redmule_axi_mem_responder #(
        .RD_LATENCY (RD_LAT)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .axi_req_i (req),
        .axi_rsp_o (rsp),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] rs, input logic l, input logic [3:0] id);
        exp_r.push_back('{data: d, resp: rs, last: l, id: id});
    endtask

    // Monitor: compare every completed R/B handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (rsp.r_valid && req.r_ready) begin
                if (exp_r.size() == 0) begin
                    check("r_unexpected", 32'd1, 32'd0);
                end else begin
                    r_exp_t e;
                    e = exp_r.pop_front();
                    check("r_data", rsp.r.data, e.data);
                    check("r_resp", 32'(rsp.r.resp), 32'(e.resp));
                    check("r_last", 32'(rsp.r.last), 32'(e.last));
                    check("r_id", 32'(rsp.r.id), 32'(e.id));
                end
            end
            if (rsp.b_valid && req.b_ready) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected", 32'd1, 32'd0);
                end else begin
                    b_exp_t e;
                    e = exp_b.pop_front();
                    check("b_resp", 32'(rsp.b.resp), 32'(e.resp));
                    check("b_id", 32'(rsp.b.id), 32'(e.id));
                end
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [1:0] burst, input int n,
                            input logic [3:0] id, input logic [1:0] exp_resp);
        int g;
        exp_b.push_back('{id: id, resp: exp_resp});
        req.aw.id    = id;
        req.aw.addr  = addr;
        req.aw.len   = 8'(n - 1);
        req.aw.size  = 3'd2;
        req.aw.burst = burst;
        req.aw_valid = 1'b1;
        g = 0;
        while (!rsp.aw_ready && g < 100) begin tick(); g++; end
        check("aw_ready_timeout", 32'(g < 100), 32'd1);
        tick();
        req.aw_valid = 1'b0;
        check("w_ready_after_aw", 32'(rsp.w_ready), 32'd1);
        check("busy_write", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            req.w.data  = wdata[i];
            req.w.strb  = wstrb[i];
            req.w.last  = (i == n - 1);
            req.w_valid = 1'b1;
            g = 0;
            while (!rsp.w_ready && g < 100) begin tick(); g++; end
            tick();
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        check("b_valid_after_wlast", 32'(rsp.b_valid), 32'd1);
        req.b_ready = 1'b1;
        g = 0;
        while (!rsp.b_valid && g < 100) begin tick(); g++; end
        tick();
        req.b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [1:0] burst, input int n,
                           input logic [3:0] id, input int hold);
        int g;
        logic [31:0] first;
        req.ar.id    = id;
        req.ar.addr  = addr;
        req.ar.len   = 8'(n - 1);
        req.ar.size  = 3'd2;
        req.ar.burst = burst;
        req.ar_valid = 1'b1;
        g = 0;
        while (!rsp.ar_ready && g < 100) begin tick(); g++; end
        check("ar_ready_timeout", 32'(g < 100), 32'd1);
        tick();
        req.ar_valid = 1'b0;
        req.r_ready  = (hold == 0);
        g = 0;
        while (!rsp.r_valid && g < 100) begin tick(); g++; end
        check("rd_latency", 32'(g), 32'(RD_LAT + 1));
        if (hold > 0) begin
            first = rsp.r.data;
            for (int k = 0; k < hold; k++) begin
                tick();
                check("bp_r_valid", 32'(rsp.r_valid), 32'd1);
                check("bp_r_data", rsp.r.data, first);
            end
            req.r_ready = 1'b1;
        end
        for (int b = 0; b < n; b++) begin
            g = 0;
            while (!rsp.r_valid && g < 100) begin tick(); g++; end
            check("r_beat_timeout", 32'(g < 100), 32'd1);
            tick();
        end
        req.r_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_ni = 1'b0;
        req    = '0;
        repeat (3) tick();
        check("rst_aw_ready", 32'(rsp.aw_ready), 32'd0);
        check("rst_ar_ready", 32'(rsp.ar_ready), 32'd0);
        check("rst_w_ready", 32'(rsp.w_ready), 32'd0);
        check("rst_b_valid", 32'(rsp.b_valid), 32'd0);
        check("rst_r_valid", 32'(rsp.r_valid), 32'd0);
        check("rst_r_last", 32'(rsp.r.last), 32'd0);
        check("rst_r_data", rsp.r.data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_ni = 1'b1;
        tick();
        check("post_rst_aw_ready", 32'(rsp.aw_ready), 32'd1);
        check("post_rst_ar_ready", 32'(rsp.ar_ready), 32'd1);

        // Single write then read.
        wdata[0] = 32'hDEAD_BEEF; wstrb[0] = 4'hF;
        do_write(32'h100, BURST_INCR, 1, 4'h1, RESP_OKAY);
        push_r(32'hDEAD_BEEF, RESP_OKAY, 1'b1, 4'h2);
        do_read(32'h100, BURST_INCR, 1, 4'h2, 0);
        check("busy_idle", 32'(busy), 32'd0);

        // Burst with a partial strobe over a prior value.
        wdata[0] = 32'hAAAA_AAAA; wstrb[0] = 4'hF;
        do_write(32'h208, BURST_INCR, 1, 4'h3, RESP_OKAY);
        wdata[0] = 32'h1111_1111; wstrb[0] = 4'hF;
        wdata[1] = 32'h2222_2222; wstrb[1] = 4'hF;
        wdata[2] = 32'h3333_3333; wstrb[2] = 4'h3;
        wdata[3] = 32'h4444_4444; wstrb[3] = 4'hF;
        do_write(32'h200, BURST_INCR, 4, 4'h4, RESP_OKAY);
        push_r(32'h1111_1111, RESP_OKAY, 1'b0, 4'h5);
        push_r(32'h2222_2222, RESP_OKAY, 1'b0, 4'h5);
        push_r(32'hAAAA_3333, RESP_OKAY, 1'b0, 4'h5);
        push_r(32'h4444_4444, RESP_OKAY, 1'b1, 4'h5);
        do_read(32'h200, BURST_INCR, 4, 4'h5, 0);

        // FIXED bursts stay on one word.
        wdata[0] = 32'h1234_5678; wstrb[0] = 4'hF;
        wdata[1] = 32'h9ABC_DEF0; wstrb[1] = 4'hF;
        do_write(32'h180, BURST_FIXED, 2, 4'h6, RESP_OKAY);
        push_r(32'h9ABC_DEF0, RESP_OKAY, 1'b0, 4'h7);
        push_r(32'h9ABC_DEF0, RESP_OKAY, 1'b1, 4'h7);
        do_read(32'h180, BURST_FIXED, 2, 4'h7, 0);

        // R backpressure on beat 0.
        push_r(32'h1111_1111, RESP_OKAY, 1'b0, 4'h8);
        push_r(32'h2222_2222, RESP_OKAY, 1'b1, 4'h8);
        do_read(32'h200, BURST_INCR, 2, 4'h8, 5);

        // Conflict: W beat lands in the cycle of the first read fetch.
        req.aw.id = 4'h9; req.aw.addr = 32'h300; req.aw.len = 8'd0;
        req.aw.size = 3'd2; req.aw.burst = BURST_INCR; req.aw_valid = 1'b1;
        g = 0;
        while (!rsp.aw_ready && g < 100) begin tick(); g++; end
        tick();
        req.aw_valid = 1'b0;
        push_r(32'hDEAD_BEEF, RESP_OKAY, 1'b1, 4'hA);
        req.ar.id = 4'hA; req.ar.addr = 32'h100; req.ar.len = 8'd0;
        req.ar.size = 3'd2; req.ar.burst = BURST_INCR; req.ar_valid = 1'b1;
        check("cf_ar_ready", 32'(rsp.ar_ready), 32'd1);
        tick();
        req.ar_valid = 1'b0;
        req.r_ready  = 1'b1;
        tick();
        tick();
        exp_b.push_back('{id: 4'h9, resp: RESP_OKAY});
        req.w.data = 32'h5A5A_5A5A; req.w.strb = 4'hF; req.w.last = 1'b1;
        req.w_valid = 1'b1;
        req.b_ready = 1'b1;
        tick();
        req.w_valid = 1'b0; req.w.last = 1'b0;
        check("cf_r_valid_delayed", 32'(rsp.r_valid), 32'd0);
        check("cf_b_valid", 32'(rsp.b_valid), 32'd1);
        tick();
        check("cf_r_valid", 32'(rsp.r_valid), 32'd1);
        tick();
        req.b_ready = 1'b0;
        req.r_ready = 1'b0;
        push_r(32'h5A5A_5A5A, RESP_OKAY, 1'b1, 4'hB);
        do_read(32'h300, BURST_INCR, 1, 4'hB, 0);

        // Out-of-range access one byte-span past the array.
        wdata[0] = 32'h0BAD_F00D; wstrb[0] = 4'hF;
        do_write(32'h0, BURST_INCR, 1, 4'hC, RESP_OKAY);
        wdata[0] = 32'hCAFE_F00D; wstrb[0] = 4'hF;
        do_write(32'h4000, BURST_INCR, 1, 4'hD, OOR_RESP);
        push_r(OOR_RDATA, OOR_RESP, 1'b1, 4'hE);
        do_read(32'h4000, BURST_INCR, 1, 4'hE, 0);
        push_r(W0_DATA, RESP_OKAY, 1'b1, 4'hF);
        do_read(32'h0, BURST_INCR, 1, 4'hF, 0);

        // Reset in the middle of R_WAIT drops the read.
        req.ar.id = 4'h1; req.ar.addr = 32'h200; req.ar.len = 8'd0;
        req.ar.burst = BURST_INCR; req.ar_valid = 1'b1;
        g = 0;
        while (!rsp.ar_ready && g < 100) begin tick(); g++; end
        tick();
        req.ar_valid = 1'b0;
        tick();
        rst_ni = 1'b0;
        tick();
        check("mid_rst_r_valid", 32'(rsp.r_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst_ni = 1'b1;
        tick();
        check("mid_rst_ar_ready", 32'(rsp.ar_ready), 32'd1);
        check("mid_rst_r_valid_after", 32'(rsp.r_valid), 32'd0);
        push_r(32'h1111_1111, RESP_OKAY, 1'b1, 4'h2);
        do_read(32'h200, BURST_INCR, 1, 4'h2, 0);

        repeat (5) tick();
        check("exp_r_drained", 32'(exp_r.size()), 32'd0);
        check("exp_b_drained", 32'(exp_b.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
